// File: rtl/sfifo_pkg.sv
// Shared definitions for the 32-bit synchronous FIFO and its drain stages.
package sfifo_pkg;

  localparam int unsigned FifoDataW = 32;
  localparam int unsigned FifoByteW = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StSend = 2'd2
  } ser_state_e;

  function automatic int unsigned beats_per_word(input int unsigned data_w,
                                                 input int unsigned byte_w);
    return data_w / byte_w;
  endfunction

endpackage

// File: rtl/word_byte_shifter.sv
// Holds one FIFO word and presents it a byte at a time; the byte index only moves on advance.
module word_byte_shifter import sfifo_pkg::*; #(
  parameter int unsigned DATA_W    = FifoDataW,
  parameter int unsigned BYTE_W    = FifoByteW,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [DATA_W-1:0] word,
  output logic [BYTE_W-1:0] cur_byte,
  output logic              last
);

  localparam int unsigned Beats = beats_per_word(DATA_W, BYTE_W);
  localparam int unsigned IdxW  = (Beats > 1) ? $clog2(Beats) : 1;

  logic [DATA_W-1:0] word_q;
  logic [IdxW-1:0]   idx_q;
  logic [IdxW-1:0]   sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (load) begin
      word_q <= word;
      idx_q  <= '0;
    end else if (advance) begin
      idx_q <= last ? '0 : idx_q + IdxW'(1);
    end
  end

  always_comb begin
    // Byte lane in the word, counted from the least significant end.
    sel      = MSB_FIRST ? (IdxW'(Beats - 1) - idx_q) : idx_q;
    cur_byte = word_q[sel * BYTE_W +: BYTE_W];
    last     = (idx_q == IdxW'(Beats - 1));
  end

endmodule

// File: rtl/sfifo_byte_serializer.sv
// Drains FIFO words and emits them as a valid/ready byte stream; pops only when a word can go out.
module sfifo_byte_serializer import sfifo_pkg::*; #(
  parameter int unsigned DATA_W    = FifoDataW,
  parameter int unsigned BYTE_W    = FifoByteW,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_fifo_empty,
  output logic              o_fifo_rd,
  input  logic [DATA_W-1:0] i_fifo_data,
  output logic [BYTE_W-1:0] o_byte,
  output logic              o_byte_vld,
  input  logic              i_byte_rdy,
  output logic              o_last_byte,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_word_cnt
);

  ser_state_e       state_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic             load;
  logic             advance;
  logic             shift_last;
  logic             last_accept;

  word_byte_shifter #(
    .DATA_W   (DATA_W),
    .BYTE_W   (BYTE_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .advance (advance),
    .word    (i_fifo_data),
    .cur_byte(o_byte),
    .last    (shift_last)
  );

  always_comb begin
    load        = (state_q == StWait);
    advance     = (state_q == StSend) && i_byte_rdy;
    last_accept = advance && shift_last;
    o_fifo_rd   = 1'b0;
    unique case (state_q)
      StIdle:  o_fifo_rd = !i_fifo_empty;
      // Refill in the same cycle the last byte leaves, so only WAIT separates words.
      StSend:  o_fifo_rd = last_accept && !i_fifo_empty;
      default: o_fifo_rd = 1'b0;
    endcase
    if (rst) begin
      o_fifo_rd = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      word_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!i_fifo_empty) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          state_q <= StSend;
        end
        StSend: begin
          if (last_accept) begin
            word_cnt_q <= word_cnt_q + CNT_W'(1);
            state_q    <= i_fifo_empty ? StIdle : StWait;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_byte_vld  = (state_q == StSend);
  assign o_last_byte = (state_q == StSend) && shift_last;
  assign o_busy      = (state_q != StIdle);
  assign o_word_cnt  = word_cnt_q;

endmodule

// File: doc/sfifo_byte_serializer.md
# sfifo_byte_serializer

Downstream drain stage for the 32-bit synchronous FIFO. It pops words from the FIFO read port and emits each word as 4 bytes on a valid/ready byte stream toward the narrow byte-wide datapath. It owns the FIFO read strobe and absorbs downstream back-pressure, so the FIFO is popped only when a whole word can be shifted out.

## Interface
Parameters:
- DATA_W, 32, FIFO word width; must be an integer multiple of BYTE_W.
- BYTE_W, 8, output byte width.
- MSB_FIRST, 1, byte order: 1 sends bits [31:24] first, 0 sends bits [7:0] first.
- CNT_W, 16, width of the word counter.

Ports:
- clk, in, 1, sole clock; all logic is on the rising edge.
- rst, in, 1, synchronous, active-high reset.
- i_fifo_empty, in, 1, FIFO empty flag.
- o_fifo_rd, out, 1, FIFO read strobe; one pop per cycle asserted.
- i_fifo_data, in, DATA_W, FIFO read data; valid the cycle after o_fifo_rd.
- o_byte, out, BYTE_W, current output byte.
- o_byte_vld, out, 1, o_byte is valid.
- i_byte_rdy, in, 1, downstream accepts o_byte this cycle.
- o_last_byte, out, 1, o_byte is the final byte of its word; qualified by o_byte_vld.
- o_busy, out, 1, FSM is not in IDLE.
- o_word_cnt, out, CNT_W, count of fully sent words; wraps modulo 2^CNT_W.

## Operation
- Beats per word: N = DATA_W/BYTE_W (4 by default). A byte index counter runs 0..N-1.
- FSM states:
  - IDLE
    - o_fifo_rd = !i_fifo_empty, driven combinationally.
    - If !i_fifo_empty, go to WAIT.
  - WAIT
    - Capture i_fifo_data into the shift register.
    - Clear the byte index.
    - Go to SEND.
  - SEND
    - o_byte_vld = 1.
    - o_byte = the byte selected by the byte index and MSB_FIRST.
    - On vld && rdy, increment the byte index.
    - On acceptance of the last byte:
      - Increment o_word_cnt.
      - If !i_fifo_empty: assert o_fifo_rd the same cycle and go to WAIT.
      - Otherwise go to IDLE.
- o_fifo_rd is never asserted while i_fifo_empty = 1. It is never asserted in WAIT, or in SEND before the last-byte handshake.
- i_fifo_data is sampled only at the end of WAIT and ignored at all other times.
- Back-pressure: while o_byte_vld = 1 and i_byte_rdy = 0, o_byte, o_last_byte and the FSM state hold unchanged. o_byte_vld never drops before acceptance.
- i_byte_rdy is ignored outside SEND.
- o_last_byte = (state == SEND) && (byte index == N-1).

## Timing
- Reset values:
  - state = IDLE.
  - o_fifo_rd = 0, o_byte_vld = 0, o_last_byte = 0, o_busy = 0.
  - o_byte = 0, shift register = 0, byte index = 0, o_word_cnt = 0.
- Reset asserted mid-word: the next edge returns to IDLE and the partial word is discarded. No FIFO pop is issued in the reset cycle; o_fifo_rd is forced to 0 while rst = 1.
- Latency:
  - Pop in cycle T (o_fifo_rd = 1).
  - Word captured at the end of T+1.
  - First byte valid in T+2.
- Throughput with rdy held high and the FIFO non-empty: N bytes per N+1 cycles. The single bubble between words is the WAIT cycle.
- A word accepted while the FIFO holds exactly 1 entry: that entry is popped in the same cycle, and the FSM goes to WAIT, not IDLE.
- o_word_cnt updates one edge after the last-byte handshake and wraps from 2^CNT_W-1 to 0.

## Structure
- Shared package sfifo_pkg holds:
  - the state encoding: IDLE = 2'd0, WAIT = 2'd1, SEND = 2'd2;
  - the default DATA_W and BYTE_W constants shared with the FIFO.
- One sub-module: word_byte_shifter.
  - Inputs: load, advance, DATA_W word.
  - Outputs: current byte, last flag.
  - Contains the byte index and honours MSB_FIRST.
- The FSM, FIFO strobe and counter live in the top module.

## Test plan
- Reset, then FIFO holds 0x11223344, rdy = 1, MSB_FIRST = 1:
  - one o_fifo_rd pulse;
  - bytes 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles starting 2 cycles after the pulse;
  - o_last_byte high on 0x44;
  - o_word_cnt = 1, then IDLE.
- Back-pressure: drop rdy for 3 cycles while 0x22 is presented:
  - o_byte stays 0x22 and vld stays high for those cycles;
  - no extra o_fifo_rd;
  - the sequence resumes with 0x33.
- Back-to-back: 32 words with data = index, rdy = 1:
  - exactly 32 pops;
  - 128 bytes in order, in 160 cycles;
  - one bubble per word;
  - o_word_cnt = 32;
  - o_fifo_rd never high while i_fifo_empty = 1.
- MSB_FIRST = 0, word 0xA1B2C3D4 -> bytes 0xD4, 0xC3, 0xB2, 0xA1.
- Reset asserted after the second byte of 0xDEADBEEF:
  - the next cycle shows vld = 0, o_busy = 0, o_word_cnt = 0;
  - the next FIFO word is sent whole, starting from its first byte.
- Preload o_word_cnt near the wrap point (force to 0xFFFF), send 1 word -> count reads 0x0000.
